// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: request, shared-ALU and response signals of the round-robin ALU scheduler
interface alu_rr_scheduler_if #(parameter int WIDTH = 8, parameter int OPCODE = 3, parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*OPCODE-1:0] req_op_code;
  logic [NUM_REQ*WIDTH-1:0] req_data_in1;
  logic [NUM_REQ*WIDTH-1:0] req_data_in2;
  logic [OPCODE-1:0] alu_op_code;
  logic [WIDTH-1:0] alu_data_in1;
  logic [WIDTH-1:0] alu_data_in2;
  logic alu_valid_data;
  logic [WIDTH-1:0] alu_data_out;
  logic alu_carry_out;
  logic alu_zero_flag;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_carry;
  logic rsp_zero;
  logic rsp_err;
  logic [15:0] ops_done;
  modport slave (
    input req_valid, req_op_code, req_data_in1, req_data_in2, alu_data_out, alu_carry_out, alu_zero_flag, rsp_ready,
    output req_ready, alu_op_code, alu_data_in1, alu_data_in2, alu_valid_data,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err, ops_done
  );
  modport master (
    output req_valid, req_op_code, req_data_in1, req_data_in2, alu_data_out, alu_carry_out, alu_zero_flag, rsp_ready,
    input req_ready, alu_op_code, alu_data_in1, alu_data_in2, alu_valid_data,
    input rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err, ops_done
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU; ALU_RR_SCHED_ILLEGAL_OP_EN traps op 3'b101
module alu_rr_scheduler #(parameter int WIDTH = 8, parameter int OPCODE = 3, parameter int NUM_REQ = 4) (
  input logic clk,
  input logic rst,
  alu_rr_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, grant, nxt_ptr, rsp_id;
  logic found, rsp_valid, rsp_carry, rsp_zero;
  logic [OPCODE-1:0] cmd_op, g_op;
  logic [WIDTH-1:0] cmd_a, cmd_b, g_a, g_b, rsp_data;
  logic [15:0] ops_done;
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign g_op = bus.req_op_code[int'(grant)*OPCODE +: OPCODE];
  assign g_a = bus.req_data_in1[int'(grant)*WIDTH +: WIDTH];
  assign g_b = bus.req_data_in2[int'(grant)*WIDTH +: WIDTH];
  assign nxt_ptr = (int'(grant) == NUM_REQ-1) ? '0 : grant + 1'b1;
  // a handshake happens exactly when IDLE finds a valid requester
  assign bus.req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << grant : '0;
  assign bus.alu_op_code = cmd_op;
  assign bus.alu_data_in1 = cmd_a;
  assign bus.alu_data_in2 = cmd_b;
  assign bus.alu_valid_data = state == EXEC;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_data = rsp_data;
  assign bus.rsp_carry = rsp_carry;
  assign bus.rsp_zero = rsp_zero;
  assign bus.ops_done = ops_done;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
  logic rsp_err;
  assign bus.rsp_err = rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cmd_op <= '0;
      cmd_a <= '0;
      cmd_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
      ops_done <= '0;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          rr_ptr <= nxt_ptr;
          rsp_id <= grant;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
          // trapped ops bypass the ALU, so its inputs keep their last value
          if (g_op == OPCODE'(5)) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_data <= '0;
            rsp_carry <= 1'b0;
            rsp_zero <= 1'b1;
            rsp_err <= 1'b1;
          end else begin
            state <= EXEC;
            cmd_op <= g_op;
            cmd_a <= g_a;
            cmd_b <= g_b;
          end
`else
          state <= EXEC;
          cmd_op <= g_op;
          cmd_a <= g_a;
          cmd_b <= g_b;
`endif
        end
        EXEC: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_data <= bus.alu_data_out;
          rsp_carry <= bus.alu_carry_out;
          rsp_zero <= bus.alu_zero_flag;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
          rsp_err <= 1'b0;
`endif
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          ops_done <= ops_done + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration, ALU sequencing, backpressure, reset and illegal ops
module tb_alu_rr_scheduler;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [8:0] alu_res;
  logic [3:0] exp_rdy [13] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1};
  always #5 clk = ~clk;
  alu_rr_scheduler_if bus();
  alu_rr_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  // reference ALU: add/sub/and/or/xor/shl(in2<<1); 101 and 110 unimplemented
  always_comb begin
    case (bus.alu_op_code)
      3'b000: alu_res = {1'b0, bus.alu_data_in1} + {1'b0, bus.alu_data_in2};
      3'b001: alu_res = {1'b0, bus.alu_data_in1 - bus.alu_data_in2};
      3'b010: alu_res = {1'b0, bus.alu_data_in1 & bus.alu_data_in2};
      3'b011: alu_res = {1'b0, bus.alu_data_in1 | bus.alu_data_in2};
      3'b100: alu_res = {1'b0, bus.alu_data_in1 ^ bus.alu_data_in2};
      3'b111: alu_res = {1'b0, bus.alu_data_in2 << 1};
      default: alu_res = 9'd0;
    endcase
  end
  assign bus.alu_data_out = alu_res[7:0];
  assign bus.alu_carry_out = alu_res[8];
  assign bus.alu_zero_flag = alu_res[7:0] == 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op_code[i*3 +: 3] = op;
    bus.req_data_in1[i*8 +: 8] = a;
    bus.req_data_in2[i*8 +: 8] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    set_req(i, op, a, b);
    #1;
    for (int k = 0; k < 20 && !bus.req_ready[i]; k++) tick();
    chk("grant_wait", bus.req_ready[i], 1);
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp;
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) tick();
    chk("rsp_wait", bus.rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '1;
    bus.req_op_code = '0;
    bus.req_data_in1 = '0;
    bus.req_data_in2 = '0;
    bus.rsp_ready = 1'b0;
    tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ops_done", bus.ops_done, 0);
    chk("rst_alu_valid", bus.alu_valid_data, 0);
    chk("rst_alu_in1", bus.alu_data_in1, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    // single add with carry out
    bus.rsp_ready = 1'b1;
    set_req(0, 3'b000, 8'hF0, 8'h20);
    #1;
    chk("t1_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    chk("t1_exec", bus.alu_valid_data, 1);
    chk("t1_alu_in1", bus.alu_data_in1, 8'hF0);
    chk("t1_no_rsp", bus.rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_data", bus.rsp_data, 8'h10);
    chk("t1_carry", bus.rsp_carry, 1);
    chk("t1_zero", bus.rsp_zero, 0);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_err", bus.rsp_err, 0);
    tick();
    chk("t1_rsp_done", bus.rsp_valid, 0);
    chk("t1_ops_done", bus.ops_done, 1);
    // all four requesting: rotation 0,1,2,3,0 every three cycles
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 3'b000, 8'(i*16), 8'h01);
    #1;
    for (int c = 0; c < 13; c++) begin
      chk($sformatf("t2_ready_c%0d", c), bus.req_ready, exp_rdy[c]);
      if (c % 3 == 2) begin
        chk($sformatf("t2_id_c%0d", c), bus.rsp_id, c / 3);
        chk($sformatf("t2_data_c%0d", c), bus.rsp_data, (c / 3) * 16 + 1);
      end
      tick();
    end
    bus.req_valid = '0;
    // response backpressure holds everything stable
    do_reset();
    set_req(1, 3'b010, 8'h3C, 8'h0F);
    #1;
    chk("t3_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", bus.rsp_valid, 1);
      chk("t3_hold_data", bus.rsp_data, 8'h0C);
      chk("t3_hold_id", bus.rsp_id, 1);
      chk("t3_hold_ready", bus.req_ready, 0);
      chk("t3_hold_alu", bus.alu_valid_data, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_pre_hs", bus.rsp_valid, 1);
    tick();
    chk("t3_post_hs", bus.rsp_valid, 0);
    chk("t3_ops_done", bus.ops_done, 1);
    chk("t3_next_grant", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    // sub to zero, then shift left of operand 2
    do_reset();
    bus.rsp_ready = 1'b1;
    issue(0, 3'b001, 8'h05, 8'h05);
    wait_rsp();
    chk("t4_sub_data", bus.rsp_data, 8'h00);
    chk("t4_sub_zero", bus.rsp_zero, 1);
    chk("t4_sub_carry", bus.rsp_carry, 0);
    tick();
    issue(0, 3'b111, 8'h00, 8'h81);
    wait_rsp();
    chk("t4_shl_data", bus.rsp_data, 8'h02);
    chk("t4_shl_carry", bus.rsp_carry, 0);
    chk("t4_shl_zero", bus.rsp_zero, 0);
    tick();
    chk("t4_ops_done", bus.ops_done, 2);
    // reset while in EXEC; pointer must restart at 0
    set_req(2, 3'b000, 8'h01, 8'h01);
    #1;
    chk("t5_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    chk("t5_exec", bus.alu_valid_data, 1);
    #1;
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_ops_done", bus.ops_done, 0);
    chk("t5_alu_valid", bus.alu_valid_data, 0);
    chk("t5_ready_in_rst", bus.req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_first_grant", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    tick();
    // op 101: trapped when the macro is set, executed otherwise
    do_reset();
    set_req(3, 3'b101, 8'h12, 8'h34);
    #1;
    chk("t6_ready", bus.req_ready, 4'b1000);
    chk("t6_alu_idle", bus.alu_valid_data, 0);
    tick();
    bus.req_valid = '0;
    chk("t6_c1_valid", bus.rsp_valid, ILL);
    chk("t6_c1_alu", bus.alu_valid_data, !ILL);
    tick();
    chk("t6_c2_valid", bus.rsp_valid, 1);
    chk("t6_err", bus.rsp_err, ILL);
    chk("t6_data", bus.rsp_data, 0);
    chk("t6_zero", bus.rsp_zero, 1);
    chk("t6_carry", bus.rsp_carry, 0);
    chk("t6_id", bus.rsp_id, 3);
    chk("t6_c2_alu", bus.alu_valid_data, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t6_done", bus.rsp_valid, 0);
    chk("t6_ops_done", bus.ops_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
